// File: rtl/noc_pkg.sv
// Shared flit definitions for the NoC router and its network interfaces.
// A flit is {payload[12:0], dst[1:0], valid}.
package noc_pkg;

    localparam int FLIT_W    = 16;
    localparam int ADDR_W    = 2;
    localparam int PAYLOAD_W = 13;

    localparam int VALID_BIT   = 0;
    localparam int DST_LSB     = 1;
    localparam int PAYLOAD_LSB = 3;

    typedef enum logic [ADDR_W-1:0] {
        East  = 2'b00,
        West  = 2'b01,
        Local = 2'b10
    } dir_e;

    typedef struct packed {
        logic [PAYLOAD_W-1:0] payload;
        logic [ADDR_W-1:0]    dst;
        logic                 valid;
    } flit_t;

    function automatic flit_t make_flit(input logic [ADDR_W-1:0] dst,
                                        input logic [PAYLOAD_W-1:0] payload);
        flit_t f;
        f.payload = payload;
        f.dst     = dst;
        f.valid   = 1'b1;
        return f;
    endfunction

endpackage

// File: rtl/noc_local_ni_if.sv
// PE-side and router-Local-side signals of the local network interface.
// slave is the NI's view, master is the view of whatever drives it.
interface noc_local_ni_if;
    import noc_pkg::*;

    logic                  tx_valid;
    logic [ADDR_W-1:0]     tx_dst;
    logic [PAYLOAD_W-1:0]  tx_payload;
    logic                  tx_ready;

    logic [FLIT_W-1:0]     dataInL;
    logic                  writeL;
    logic                  fullL;
    logic                  almost_fullL;

    logic [FLIT_W-1:0]     dataOutL;
    logic                  writeOutL;
    logic                  readFullL;
    logic                  read_almostfullL;

    logic                  rx_valid;
    logic [ADDR_W-1:0]     rx_dst;
    logic [PAYLOAD_W-1:0]  rx_payload;
    logic                  rx_ready;
    logic                  rx_overflow;

    logic [15:0]           tx_count;
    logic [15:0]           rx_count;

    modport slave (
        input  tx_valid, tx_dst, tx_payload,
        input  fullL, almost_fullL,
        input  dataOutL, writeOutL,
        input  rx_ready,
        output tx_ready, dataInL, writeL,
        output readFullL, read_almostfullL,
        output rx_valid, rx_dst, rx_payload, rx_overflow,
        output tx_count, rx_count
    );

    modport master (
        output tx_valid, tx_dst, tx_payload,
        output fullL, almost_fullL,
        output dataOutL, writeOutL,
        output rx_ready,
        input  tx_ready, dataInL, writeL,
        input  readFullL, read_almostfullL,
        input  rx_valid, rx_dst, rx_payload, rx_overflow,
        input  tx_count, rx_count
    );

endinterface

// File: rtl/noc_rx_fifo.sv
// Receive FIFO: a push into a full FIFO is still stored when a pop happens the
// same cycle; otherwise it is dropped and a sticky overflow flag is raised.
module noc_rx_fifo #(
    parameter int DW        = 15,
    parameter int DEPTH     = 4,
    parameter int AF_MARGIN = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic [DW-1:0] din,
    input  logic          popReq,
    output logic [DW-1:0] dout,
    output logic          valid,
    output logic          full,
    output logic          almostFull,
    output logic          stored,
    output logic          overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] AF_CNT   = CW'(DEPTH - AF_MARGIN);

    if (((DEPTH & (DEPTH - 1)) != 0) || (DEPTH < 4)) begin : gBadDepth
        $error("noc_rx_fifo: DEPTH must be a power of 2 and at least 4");
    end

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wrPtr;
    logic [AW-1:0] rdPtr;
    logic [CW-1:0] count;
    logic          pop;

    assign valid      = (count != '0);
    assign full       = (count == FULL_CNT);
    assign almostFull = (count >= AF_CNT);
    assign pop        = popReq & valid;
    assign stored     = push & (!full | pop);
    assign dout       = valid ? mem[rdPtr] : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wrPtr    <= '0;
            rdPtr    <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (stored) wrPtr <= wrPtr + AW'(1);
            if (pop)    rdPtr <= rdPtr + AW'(1);
            count <= count + CW'(stored) - CW'(pop);
            if (push && !stored) overflow <= 1'b1;
        end
    end

    // Storage is not reset; count gates every read so stale entries never leak out.
    always_ff @(posedge clk) begin
        if (stored) mem[wrPtr] <= din;
    end

endmodule

// File: rtl/noc_local_ni.sv
// Local network interface: PE beats -> flits into the router Local input through
// a one-entry holding register, router Local output -> rx FIFO -> PE.
import noc_pkg::*;

module noc_local_ni #(
    parameter int          WIDTH     = 16,
    parameter logic [1:0]  LOCAL_IP  = 2'b00,
    parameter int          RX_DEPTH  = 4,
    parameter int          AF_MARGIN = 2
) (
    input  logic           clk,
    input  logic           reset,
    noc_local_ni_if.slave  ni
);

    localparam int RX_DW = FLIT_W - DST_LSB;

    if ((WIDTH != FLIT_W) || ($bits(LOCAL_IP) != ADDR_W)) begin : gBadCfg
        $error("noc_local_ni: flit width is fixed at 16 with a 2-bit address");
    end

    flit_t       holdFlit;
    logic        holdV;
    logic        wrtAble;
    logic        writeL;
    logic        txReady;
    logic        accept;
    logic [15:0] txCount;

    // tx_ready is forced low while reset is asserted so every output reads 0.
    assign writeL  = holdV & wrtAble;
    assign txReady = !reset & (!holdV | writeL);
    assign accept  = ni.tx_valid & txReady;

    assign ni.writeL   = writeL;
    assign ni.tx_ready = txReady;
    assign ni.dataInL  = holdV ? holdFlit : '0;
    assign ni.tx_count = txCount;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            holdV    <= 1'b0;
            holdFlit <= '0;
            wrtAble  <= 1'b0;
            txCount  <= '0;
        end else begin
            wrtAble <= !((ni.almost_fullL & writeL) | ni.fullL);
            if (accept) begin
                holdFlit <= make_flit(ni.tx_dst, ni.tx_payload);
                holdV    <= 1'b1;
            end else if (writeL) begin
                holdV <= 1'b0;
            end
            if (writeL) txCount <= txCount + 16'd1;
        end
    end

    logic [RX_DW-1:0] rxHead;
    logic             rxValid;
    logic             rxFull;
    logic             rxAlmostFull;
    logic             rxStored;
    logic             rxOverflow;
    logic [15:0]      rxCount;

    // Only flits with the valid bit set count as writes; the FIFO keeps bits [15:1].
    noc_rx_fifo #(
        .DW        (RX_DW),
        .DEPTH     (RX_DEPTH),
        .AF_MARGIN (AF_MARGIN)
    ) uRxFifo (
        .clk        (clk),
        .reset      (reset),
        .push       (ni.writeOutL & ni.dataOutL[VALID_BIT]),
        .din        (ni.dataOutL[FLIT_W-1:DST_LSB]),
        .popReq     (ni.rx_ready),
        .dout       (rxHead),
        .valid      (rxValid),
        .full       (rxFull),
        .almostFull (rxAlmostFull),
        .stored     (rxStored),
        .overflow   (rxOverflow)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) rxCount <= '0;
        else if (rxStored) rxCount <= rxCount + 16'd1;
    end

    assign ni.rx_valid         = rxValid;
    assign ni.rx_dst           = rxHead[PAYLOAD_LSB-DST_LSB-1:0];
    assign ni.rx_payload       = rxHead[RX_DW-1:PAYLOAD_LSB-DST_LSB];
    assign ni.readFullL        = rxFull;
    assign ni.read_almostfullL = rxAlmostFull;
    assign ni.rx_overflow      = rxOverflow;
    assign ni.rx_count         = rxCount;

endmodule

// File: tb/tb_noc_local_ni.sv
// Bench for noc_local_ni: directed tx sequences, an rx vector table and a
// randomized run against queue-based tx/rx reference models.
module tb_noc_local_ni;
    import noc_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    noc_local_ni_if nif();

    noc_local_ni #(
        .WIDTH(16), .LOCAL_IP(2'b00), .RX_DEPTH(4), .AF_MARGIN(2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .ni    (nif)
    );

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        rst;
        logic        wr;
        logic [15:0] d;
        logic        rdy;
        logic        eValid;
        logic        eFull;
        logic        eAf;
        logic        eOvf;
        logic [15:0] eCnt;
        logic [12:0] ePay;
    } rxVec_t;

    rxVec_t vecs[16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        nif.tx_valid     = 1'b0;
        nif.tx_dst       = '0;
        nif.tx_payload   = '0;
        nif.fullL        = 1'b0;
        nif.almost_fullL = 1'b0;
        nif.dataOutL     = '0;
        nif.writeOutL    = 1'b0;
        nif.rx_ready     = 1'b0;
    endtask

    task automatic doReset();
        idle();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    function automatic logic [15:0] fl(input logic [1:0] d, input logic [12:0] p);
        return {p, d, 1'b1};
    endfunction

    function automatic rxVec_t mk(input logic rst, input logic wr, input logic [15:0] d,
                                  input logic rdy, input logic v, input logic f,
                                  input logic af, input logic o, input logic [15:0] c,
                                  input logic [12:0] p);
        rxVec_t r;
        r.rst = rst; r.wr = wr; r.d = d; r.rdy = rdy;
        r.eValid = v; r.eFull = f; r.eAf = af; r.eOvf = o; r.eCnt = c; r.ePay = p;
        return r;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [15:0] b2b [4];
        logic [15:0] tq[$];
        logic [14:0] rq[$];
        logic        prevBlock, expWrite, expReady, expValid, pushIt, popIt;
        int          txW, rxC;
        logic        ovf;

        b2b[0] = 16'h000B; b2b[1] = 16'h0013; b2b[2] = 16'h001B; b2b[3] = 16'h0023;

        // ---------------- reset state ----------------
        idle();
        reset = 1'b1;
        #12;
        chk("rst_tx_ready_low", nif.tx_ready, 0);
        chk("rst_writeL", nif.writeL, 0);
        chk("rst_dataInL", nif.dataInL, 0);
        tick();
        reset = 1'b0;
        #1;
        chk("rst_tx_ready_high", nif.tx_ready, 1);
        chk("rst_rx_valid", nif.rx_valid, 0);
        chk("rst_readFullL", nif.readFullL, 0);
        chk("rst_read_af", nif.read_almostfullL, 0);
        chk("rst_overflow", nif.rx_overflow, 0);
        chk("rst_tx_count", nif.tx_count, 0);
        chk("rst_rx_count", nif.rx_count, 0);
        chk("rst_rx_payload", nif.rx_payload, 0);

        // ---------------- back-to-back tx ----------------
        doReset();
        nif.tx_valid = 1'b1; nif.tx_dst = 2'b01; nif.tx_payload = 13'd1;
        #1 chk("b2b_first_no_write", nif.writeL, 0);
        tick();
        for (int k = 0; k < 4; k++) begin
            if (k < 3) nif.tx_payload = 13'(k + 2);
            else nif.tx_valid = 1'b0;
            #1;
            chk($sformatf("b2b_writeL_%0d", k), nif.writeL, 1);
            chk($sformatf("b2b_data_%0d", k), nif.dataInL, b2b[k]);
            chk($sformatf("b2b_ready_%0d", k), nif.tx_ready, 1);
            tick();
        end
        #1;
        chk("b2b_write_end", nif.writeL, 0);
        chk("b2b_tx_count", nif.tx_count, 4);
        tick();

        // ---------------- almost-full throttle ----------------
        nif.tx_valid = 1'b1; nif.tx_dst = 2'b00; nif.tx_payload = 13'd5;
        tick();
        nif.tx_payload = 13'd6; nif.almost_fullL = 1'b1;
        #1;
        chk("af_write", nif.writeL, 1);
        chk("af_write_data", nif.dataInL, fl(2'b00, 13'd5));
        tick();
        nif.almost_fullL = 1'b0; nif.tx_payload = 13'd7;
        #1;
        chk("af_throttle_writeL", nif.writeL, 0);
        chk("af_throttle_ready", nif.tx_ready, 0);
        tick();
        #1;
        chk("af_resume_writeL", nif.writeL, 1);
        chk("af_resume_data", nif.dataInL, fl(2'b00, 13'd6));
        chk("af_resume_ready", nif.tx_ready, 1);
        tick();
        nif.tx_valid = 1'b0;
        #1;
        chk("af_next_writeL", nif.writeL, 1);
        chk("af_next_data", nif.dataInL, fl(2'b00, 13'd7));
        tick();
        #1 chk("af_idle", nif.writeL, 0);
        tick();

        // ---------------- fullL held 10 cycles ----------------
        nif.fullL = 1'b1; nif.tx_valid = 1'b1; nif.tx_dst = 2'b11; nif.tx_payload = 13'd9;
        tick();
        nif.tx_payload = 13'd10;
        for (int i = 1; i < 10; i++) begin
            #1;
            chk($sformatf("full_writeL_%0d", i), nif.writeL, 0);
            chk($sformatf("full_ready_%0d", i), nif.tx_ready, 0);
            chk($sformatf("full_hold_%0d", i), nif.dataInL, fl(2'b11, 13'd9));
            tick();
        end
        nif.fullL = 1'b0;
        #1 chk("full_release_same_cycle", nif.writeL, 0);
        tick();
        #1;
        chk("full_release_writeL", nif.writeL, 1);
        chk("full_release_data", nif.dataInL, fl(2'b11, 13'd9));
        chk("full_release_ready", nif.tx_ready, 1);
        tick();
        nif.tx_valid = 1'b0;
        #1;
        chk("full_second_writeL", nif.writeL, 1);
        chk("full_second_data", nif.dataInL, fl(2'b11, 13'd10));
        tick();
        #1;
        chk("full_idle", nif.writeL, 0);
        chk("full_tx_count", nif.tx_count, 9);

        // ---------------- rx vector table ----------------
        vecs[0]  = mk(0, 1, fl(2'b10, 13'h101), 0, 1, 0, 0, 0, 1, 13'h101);
        vecs[1]  = mk(0, 1, fl(2'b10, 13'h102), 0, 1, 0, 1, 0, 2, 13'h101);
        vecs[2]  = mk(0, 1, fl(2'b10, 13'h103), 0, 1, 0, 1, 0, 3, 13'h101);
        vecs[3]  = mk(0, 1, fl(2'b10, 13'h104), 0, 1, 1, 1, 0, 4, 13'h101);
        vecs[4]  = mk(0, 1, fl(2'b10, 13'h105), 0, 1, 1, 1, 1, 4, 13'h101);
        vecs[5]  = mk(0, 0, 16'h0000,           1, 1, 0, 1, 1, 4, 13'h102);
        vecs[6]  = mk(0, 0, 16'h0000,           1, 1, 0, 1, 1, 4, 13'h103);
        vecs[7]  = mk(0, 0, 16'h0000,           1, 1, 0, 0, 1, 4, 13'h104);
        vecs[8]  = mk(0, 0, 16'h0000,           1, 0, 0, 0, 1, 4, 13'h000);
        vecs[9]  = mk(1, 0, 16'h0000,           0, 0, 0, 0, 0, 0, 13'h000);
        vecs[10] = mk(0, 1, fl(2'b10, 13'h101), 0, 1, 0, 0, 0, 1, 13'h101);
        vecs[11] = mk(0, 1, fl(2'b10, 13'h102), 0, 1, 0, 1, 0, 2, 13'h101);
        vecs[12] = mk(0, 1, fl(2'b10, 13'h103), 0, 1, 0, 1, 0, 3, 13'h101);
        vecs[13] = mk(0, 1, fl(2'b10, 13'h104), 0, 1, 1, 1, 0, 4, 13'h101);
        vecs[14] = mk(0, 1, fl(2'b10, 13'h105), 1, 1, 1, 1, 0, 5, 13'h102);
        vecs[15] = mk(0, 1, 16'h0F0E,           0, 1, 1, 1, 0, 5, 13'h102);

        doReset();
        for (int i = 0; i < 16; i++) begin
            if (vecs[i].rst) begin
                idle();
                reset = 1'b1;
                tick();
                reset = 1'b0;
            end else begin
                nif.writeOutL = vecs[i].wr;
                nif.dataOutL  = vecs[i].d;
                nif.rx_ready  = vecs[i].rdy;
                tick();
                nif.writeOutL = 1'b0;
                nif.rx_ready  = 1'b0;
            end
            #1;
            chk($sformatf("vec%0d_valid", i), nif.rx_valid, vecs[i].eValid);
            chk($sformatf("vec%0d_full", i), nif.readFullL, vecs[i].eFull);
            chk($sformatf("vec%0d_af", i), nif.read_almostfullL, vecs[i].eAf);
            chk($sformatf("vec%0d_ovf", i), nif.rx_overflow, vecs[i].eOvf);
            chk($sformatf("vec%0d_rxcnt", i), nif.rx_count, vecs[i].eCnt);
            chk($sformatf("vec%0d_payload", i), nif.rx_payload, vecs[i].ePay);
        end

        // ---------------- randomized run vs reference model ----------------
        doReset();
        prevBlock = 1'b1;
        txW = 0; rxC = 0; ovf = 1'b0;
        for (int c = 0; c < 400; c++) begin
            nif.tx_valid     = ($urandom_range(0, 99) < 60);
            nif.tx_dst       = 2'($urandom);
            nif.tx_payload   = 13'($urandom);
            nif.fullL        = ($urandom_range(0, 99) < 20);
            nif.almost_fullL = ($urandom_range(0, 99) < 25);
            nif.writeOutL    = ($urandom_range(0, 99) < 50);
            nif.dataOutL     = 16'($urandom);
            nif.rx_ready     = ($urandom_range(0, 99) < ((c < 200) ? 25 : 70));
            #1;

            expWrite = (tq.size() > 0) && !prevBlock;
            expReady = (tq.size() == 0) || expWrite;
            chk("rnd_writeL", nif.writeL, expWrite);
            if (expWrite) chk("rnd_dataInL", nif.dataInL, tq[0]);
            chk("rnd_tx_ready", nif.tx_ready, expReady);
            chk("rnd_tx_count", nif.tx_count, 16'(txW));

            expValid = (rq.size() != 0);
            chk("rnd_rx_valid", nif.rx_valid, expValid);
            chk("rnd_rx_dst", nif.rx_dst, expValid ? rq[0][1:0] : 2'b00);
            chk("rnd_rx_payload", nif.rx_payload, expValid ? rq[0][14:2] : 13'h0);
            chk("rnd_readFullL", nif.readFullL, rq.size() == 4);
            chk("rnd_read_af", nif.read_almostfullL, rq.size() >= 2);
            chk("rnd_overflow", nif.rx_overflow, ovf);
            chk("rnd_rx_count", nif.rx_count, 16'(rxC));

            if (expWrite) begin
                void'(tq.pop_front());
                txW++;
            end
            if (nif.tx_valid && expReady) tq.push_back(fl(nif.tx_dst, nif.tx_payload));
            prevBlock = nif.fullL | (nif.almost_fullL & expWrite);

            popIt  = expValid && nif.rx_ready;
            pushIt = nif.writeOutL && nif.dataOutL[0];
            if (pushIt && !(rq.size() < 4 || popIt)) ovf = 1'b1;
            if (pushIt && (rq.size() < 4 || popIt)) begin
                if (popIt) void'(rq.pop_front());
                rq.push_back(nif.dataOutL[15:1]);
                rxC++;
            end else if (popIt) begin
                void'(rq.pop_front());
            end
            tick();
        end

        // ---------------- reset mid-operation ----------------
        doReset();
        for (int k = 0; k < 3; k++) begin
            nif.writeOutL = 1'b1;
            nif.dataOutL  = fl(2'b01, 13'(k + 20));
            tick();
        end
        nif.writeOutL = 1'b0;
        nif.fullL = 1'b1; nif.tx_valid = 1'b1; nif.tx_dst = 2'b10; nif.tx_payload = 13'd33;
        tick();
        nif.tx_valid = 1'b0;
        tick();
        #1;
        chk("mid_pre_rx_valid", nif.rx_valid, 1);
        chk("mid_pre_rx_count", nif.rx_count, 3);
        chk("mid_pre_hold", nif.tx_ready, 0);
        reset = 1'b1;
        #1;
        chk("mid_rst_rx_valid", nif.rx_valid, 0);
        chk("mid_rst_writeL", nif.writeL, 0);
        chk("mid_rst_rx_count", nif.rx_count, 0);
        chk("mid_rst_tx_count", nif.tx_count, 0);
        chk("mid_rst_overflow", nif.rx_overflow, 0);
        chk("mid_rst_dataInL", nif.dataInL, 0);
        nif.fullL = 1'b0;
        tick();
        reset = 1'b0;
        #1;
        chk("mid_after_tx_ready", nif.tx_ready, 1);
        chk("mid_after_rx_valid", nif.rx_valid, 0);
        chk("mid_after_writeL", nif.writeL, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/noc_local_ni.md
Name: noc_local_ni

Overview:
- Local network interface between a PageRank processing element (PE) and the Local port of a noc_router.
- Transmit path: packs PE requests into 16-bit flits and writes them into the router's Local input FIFO, obeying the router's full/almost_full back-pressure.
- Receive path: accepts flits the router writes out on its Local output, buffers them, and hands payloads to the PE over valid/ready. It also drives full/almost_full back to the router.

Parameters:
- WIDTH, 16, flit width; fixed at 16 (flit format below).
- LOCAL_IP, 2'b00, this node's address; reported only, never filters.
- RX_DEPTH, 4, receive FIFO entries; power of 2, at least 4.
- AF_MARGIN, 2, rx almost_full asserts when count >= RX_DEPTH-AF_MARGIN.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- tx_valid  in  1  PE has a flit to send.
- tx_dst  in  2  destination node address.
- tx_payload  in  13  payload.
- tx_ready  out  1  NI accepts the tx beat this cycle.
- dataInL  out  16  flit to router Local input.
- writeL  out  1  write strobe to router Local input.
- fullL  in  1  router Local FIFO full.
- almost_fullL  in  1  router Local FIFO almost full.
- dataOutL  in  16  flit from router Local output.
- writeOutL  in  1  router write strobe.
- readFullL  out  1  rx FIFO full, to router.
- read_almostfullL  out  1  rx FIFO almost full, to router.
- rx_valid  out  1  rx FIFO head valid.
- rx_dst  out  2  head flit address field.
- rx_payload  out  13  head flit payload.
- rx_ready  in  1  PE pops the head.
- rx_overflow  out  1  sticky; a flit was dropped.
- tx_count  out  16  flits written to router; wraps.
- rx_count  out  16  flits accepted into rx FIFO; wraps.

Behaviour:
- Flit format: [0]=valid (always 1 when sent), [2:1]=dst, [15:3]=payload.
- Reset: every output is 0, including the tx holding register, wrt_able, the FIFO pointers/count, the sticky flag and both counters. tx_ready returns high the first cycle after reset deasserts.

Transmit (one-entry holding register hold_v/hold_flit):
- tx_ready = !hold_v | writeL (combinational). A beat is accepted when tx_valid & tx_ready; hold_flit <= {payload, dst, 1'b1} and hold_v <= 1.
- wrt_able is a register: it loads 0 if (almost_fullL & writeL) | fullL, else 1.
- writeL = hold_v & wrt_able; dataInL = hold_flit when hold_v, else 16'h0000.
- Latency: a beat accepted in cycle N drives writeL in N+1 if wrt_able.
- Sending a write and accepting a new beat in the same cycle is legal, giving one flit per cycle sustained.
- tx_count increments on each writeL.
- tx_dst == LOCAL_IP is legal: the router loops the flit back.

Receive:
- A write is a writeOutL cycle with dataOutL[0]==1. Writes with [0]==0 are ignored and not counted.
- The write is stored if count < RX_DEPTH, or if a pop happens in the same cycle. Otherwise the flit is dropped and rx_overflow is set until reset.
- Pop = rx_valid & rx_ready. A simultaneous push and pop leaves count unchanged.
- rx_valid = count != 0. rx_dst/rx_payload come from the head combinationally and are 0 when empty.
- readFullL = count == RX_DEPTH; read_almostfullL = count >= RX_DEPTH-AF_MARGIN. Both are combinational from the registered count.
- rx_count increments on every stored flit.
- Pointers wrap modulo RX_DEPTH; count is $clog2(RX_DEPTH)+1 bits.
- Reset mid-operation discards the holding register and all FIFO contents immediately.

Decomposition:
- Shared package noc_pkg holds:
  - FLIT_W = 16, ADDR_W = 2, PAYLOAD_W = 13.
  - Field LSB constants: VALID_BIT = 0, DST_LSB = 1, PAYLOAD_LSB = 3.
  - Direction constants East = 2'b00, West = 2'b01, Local = 2'b10.
  - Function make_flit(dst, payload).
- One sub-module: noc_rx_fifo (synchronous FIFO with count, full, almost_full, push-when-full-with-pop).

Test Plan:
- Back-to-back tx: fullL = almost_fullL = 0; 4 beats with dst 2'b01, payloads 1..4 on consecutive cycles. Required: writeL high 4 consecutive cycles starting 1 cycle after the first beat; dataInL = 16'h000B, 16'h0013, 16'h001B, 16'h0023; tx_count = 4.
- Almost-full throttle: almost_fullL = 1 during a write. Required: writeL low the next cycle and tx_ready held low; writeL resumes one cycle after almost_fullL drops.
- fullL held 10 cycles with one flit pending. Required: no writeL, tx_ready = 0, hold_flit unchanged; writeL asserts the cycle after fullL = 0 is registered.
- Rx fill, RX_DEPTH = 4, rx_ready = 0, 5 valid writes. Required: read_almostfullL after the 2nd write, readFullL after the 4th; the 5th is dropped, rx_overflow = 1, rx_count = 4. Draining then yields payloads in write order.
- Rx full with simultaneous push and pop. Required: the flit is stored, count stays 4, rx_overflow stays 0. A write with dataOutL[0] = 0 leaves rx_count unchanged.
- Assert reset for 1 cycle with 3 rx entries and hold_v = 1. Required: rx_valid = 0, writeL = 0, counters = 0, rx_overflow = 0; tx_ready = 1 the following cycle.
